// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, word type, S-box table, Rcon.
// Also holds the forward key-schedule step used by the encrypt path.
package aes_pkg;

    localparam int AES_NR   = 10;
    localparam int AES_RK_W = 128;

    typedef logic [31:0] word_t;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant byte for the step into/out of round r (1..10); 0 otherwise.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic word_t rot_word(input word_t x);
        return {x[23:0], x[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    // Forward schedule: key of round r-1 -> key of round r.
    function automatic logic [127:0] fwd_step(input logic [127:0] k,
                                              input logic [3:0]   round);
        word_t t;
        word_t n0;
        word_t n1;
        word_t n2;
        word_t n3;
        t  = sub_word(rot_word(k[31:0])) ^ {rcon(round), 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box, one byte.
// Ports: a = input byte, s = substituted byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    assign s = SBOX[a];

endmodule

// File: rtl/aes_inv_key_expand.sv
// Inverse AES-128 key schedule: loads round-NR key, walks down to round 0.
// Ports: CLK, RST_N, load/key_in, rk/rk_round/rk_valid/rk_ready, done.
module aes_inv_key_expand
    import aes_pkg::*;
#(
    parameter int NR   = AES_NR,
    parameter int RK_W = AES_RK_W
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            load,
    input  logic [RK_W-1:0] key_in,
    output logic [RK_W-1:0] rk,
    output logic [3:0]      rk_round,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic            done
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [RK_W-1:0] key_q;
    logic [RK_W-1:0] key_next;
    logic [3:0]      round_q;
    logic [3:0]      round_next;
    logic            done_q;
    logic            done_next;

    word_t w0;
    word_t w1;
    word_t w2;
    word_t w3;
    word_t p0;
    word_t p1;
    word_t p2;
    word_t p3;
    word_t rot;
    word_t sub;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // Undo the forward XOR chain; w3 of the previous round feeds its g().
    assign p3  = w3 ^ w2;
    assign p2  = w2 ^ w1;
    assign p1  = w1 ^ w0;
    assign rot = rot_word(p3);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*g +: 8]),
            .s (sub[8*g +: 8])
        );
    end

    assign p0 = w0 ^ sub ^ {rcon(round_q), 24'h0};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            key_q   <= key_next;
            round_q <= round_next;
            done_q  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        key_next   = key_q;
        round_next = round_q;
        done_next  = 1'b0;
        if (load) begin
            state_next = PRESENT;
            key_next   = key_in;
            round_next = 4'(NR);
        end else if (state == PRESENT && rk_ready) begin
            if (round_q != 4'd0) begin
                key_next   = {p0, p1, p2, p3};
                round_next = round_q - 4'd1;
            end else begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end
    end

    assign rk       = key_q;
    assign rk_round = round_q;
    assign rk_valid = (state == PRESENT);
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Scoreboard bench for aes_inv_key_expand.
// Expected keys come from a local forward expander with its own S-box.
module tb_aes_inv_key_expand;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b1;
    logic         load = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic         done;

    aes_inv_key_expand dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (load),
        .key_in   (key_in),
        .rk       (rk),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   rnd;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           accepts = 0;
    int           dones = 0;
    logic [7:0]   sb [0:255];
    logic [127:0] fks [0:10];
    logic [7:0]   rc_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] g_fn(input logic [31:0] x, input int i);
        logic [31:0] r;
        r = {x[23:0], x[31:24]};
        return {sb[r[31:24]] ^ rc_tab[i], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
    endfunction

    function automatic void expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        w[0] = k[127:96];
        w[1] = k[95:64];
        w[2] = k[63:32];
        w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = g_fn(t, i / 4 - 1);
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            fks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic void push_seq();
        for (int r = 10; r >= 0; r--)
            exp_q.push_back('{key: fks[r], rnd: 4'(r)});
    endfunction

    // Monitor: pops on every accept, checks done timing and stall stability.
    bit           done_pend = 0;
    bit           stall = 0;
    logic [127:0] s_rk;
    logic [3:0]   s_round;
    exp_t         m_e;

    always @(negedge CLK) begin
        if (!RST_N) begin
            done_pend = 0;
            stall = 0;
        end else begin
            if (done) dones++;
            chk("done", 128'(done), 128'(done_pend));
            done_pend = 0;
            if (stall) begin
                chk("stall_valid", 128'(rk_valid), 128'(1'b1));
                chk("stall_rk", rk, s_rk);
                chk("stall_round", 128'(rk_round), 128'(s_round));
            end
            stall = rk_valid && !rk_ready && !load;
            s_rk = rk;
            s_round = rk_round;
            if (rk_valid && rk_ready && !load) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_accept actual_round=%0d required=none",
                             rk_round);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rk", rk, m_e.key);
                    chk("rk_round", 128'(rk_round), 128'(m_e.rnd));
                    if (m_e.rnd == 4'd0) done_pend = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue_load(input logic [127:0] k);
        load = 1'b1;
        key_in = k;
        step();
        load = 1'b0;
    endtask

    task automatic drain(input int bound, input bit rnd_ready);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual_left=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n;
        n = 0;
        while (!(rk_valid && rk_round == r) && n < 40) begin
            step();
            n++;
        end
        if (!(rk_valid && rk_round == r)) begin
            checks++;
            failures++;
            $display("FAIL wait_round actual=%0d required=%0d", rk_round, r);
        end
    endtask

    localparam logic [127:0] CK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int a0;
    int d0;

    initial begin
        build_sbox();
        #2 RST_N = 1'b0;
        step();
        step();
        chk("reset_rk", rk, 128'h0);
        chk("reset_round", 128'(rk_round), 128'h0);
        chk("reset_valid", 128'(rk_valid), 128'h0);
        chk("reset_done", 128'(done), 128'h0);
        RST_N = 1'b1;

        // Ready high in IDLE with no load: nothing happens.
        rk_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_valid", 128'(rk_valid), 128'h0);
            chk("idle_done", 128'(done), 128'h0);
        end

        // Directed FIPS-197 walk, ready held high.
        expand(CK);
        push_seq();
        exp_q[0].key  = K10;
        exp_q[1].key  = 128'hac7766f319fadc2128d12941575c006e;
        exp_q[9].key  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_q[10].key = CK;
        a0 = accepts;
        d0 = dones;
        issue_load(K10);
        chk("load_round", 128'(rk_round), 128'd10);
        chk("load_rk", rk, K10);
        drain(40, 0);
        step();
        step();
        chk("t1_accepts", 128'(accepts - a0), 128'd11);
        chk("t1_dones", 128'(dones - d0), 128'd1);
        chk("t1_final_rk", rk, CK);
        chk("t1_final_valid", 128'(rk_valid), 128'h0);

        // Same walk with random back-pressure.
        push_seq();
        a0 = accepts;
        issue_load(K10);
        drain(300, 1);
        rk_ready = 1'b0;
        step();
        step();
        chk("t2_accepts", 128'(accepts - a0), 128'd11);

        // Load mid-walk at round 5 together with an accept.
        push_seq();
        d0 = dones;
        rk_ready = 1'b1;
        issue_load(K10);
        wait_round(4'd5);
        expand(128'h000102030405060708090a0b0c0d0e0f);
        exp_q.delete();
        push_seq();
        issue_load(fks[10]);
        chk("reload_round", 128'(rk_round), 128'd10);
        chk("reload_rk", rk, fks[10]);
        chk("reload_no_done", 128'(done), 128'h0);
        drain(40, 0);
        step();
        step();
        chk("t3_dones", 128'(dones - d0), 128'd1);

        // Asynchronous reset mid-walk at round 3.
        expand(CK);
        push_seq();
        issue_load(K10);
        wait_round(4'd3);
        #1 RST_N = 1'b0;
        exp_q.delete();
        #1;
        chk("async_valid", 128'(rk_valid), 128'h0);
        chk("async_rk", rk, 128'h0);
        chk("async_round", 128'(rk_round), 128'h0);
        step();
        step();
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_valid", 128'(rk_valid), 128'h0);
        end

        // Round trip over random cipher keys.
        for (int n = 0; n < 1000; n++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            push_seq();
            issue_load(fks[10]);
            drain(100, (n % 4) == 0);
        end
        rk_ready = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
